// File: rtl/mul_writeback_pkg.sv
// Shared processor constants and the multiply-writeback FSM state encoding.
package mul_writeback_pkg;

  localparam int PROC_DATA_W     = 16;
  localparam int PROC_REG_ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WB_LO = 3'd3,
    WB_HI = 3'd4
  } state_t;

endpackage

// File: rtl/mul_writeback_ctrl_watchdog.sv
// Cycle counter guarding the multiplier wait; expired flags the last allowed cycle.
module mul_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count cycles while enabled; clear has priority so a fresh wait starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mul_writeback_ctrl.sv
// Multiply request controller: starts the multiplier, waits for done (with a
// watchdog) and writes the 32-bit product back as two register-file writes.
module mul_writeback_ctrl
  import mul_writeback_pkg::*;
#(
  parameter int DATA_W     = PROC_DATA_W,
  parameter int REG_ADDR_W = PROC_REG_ADDR_W,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_W-1:0]     req_x,
  input  logic [DATA_W-1:0]     req_y,
  input  logic [REG_ADDR_W-1:0] req_rd,
  output logic                  mul_start,
  output logic [DATA_W-1:0]     mul_x,
  output logic [DATA_W-1:0]     mul_y,
  input  logic [2*DATA_W-1:0]   mul_product,
  input  logic                  mul_done,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  busy,
  output logic                  op_done,
  output logic                  timeout_err
);

  state_t                  state, state_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [2*DATA_W-1:0]     prod_q, prod_d;
  logic [DATA_W-1:0]       x_d, y_d, wb_data_d;
  logic [REG_ADDR_W-1:0]   wb_addr_d;
  logic                    mul_start_d, wb_en_d, op_done_d, timeout_err_d, busy_d;
  logic                    wd_clear, wd_en, wd_expired;

  mul_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign req_ready = (state == IDLE);

  // Next state plus next values of every registered output. Outputs are
  // computed for the state being entered so they are valid during that state.
  always_comb begin
    state_d       = state;
    rd_d          = rd_q;
    prod_d        = prod_q;
    x_d           = mul_x;
    y_d           = mul_y;
    wb_addr_d     = wb_addr;
    wb_data_d     = wb_data;
    mul_start_d   = 1'b0;
    wb_en_d       = 1'b0;
    op_done_d     = 1'b0;
    timeout_err_d = 1'b0;
    wd_clear      = 1'b0;
    wd_en         = 1'b0;
    case (state)
      IDLE: begin
        wd_clear = 1'b1;
        if (req_valid) begin
          x_d         = req_x;
          y_d         = req_y;
          rd_d        = req_rd;
          mul_start_d = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        wd_clear = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // done beats a coincident watchdog expiry
        if (mul_done) begin
          prod_d    = mul_product;
          wb_en_d   = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = mul_product[DATA_W-1:0];
          state_d   = WB_LO;
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      WB_LO: begin
        wb_en_d   = 1'b1;
        wb_addr_d = rd_q + REG_ADDR_W'(1);
        wb_data_d = prod_q[2*DATA_W-1:DATA_W];
        op_done_d = 1'b1;
        state_d   = WB_HI;
      end
      WB_HI: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any in-flight writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_q        <= '0;
      prod_q      <= '0;
      mul_x       <= '0;
      mul_y       <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      mul_start   <= 1'b0;
      wb_en       <= 1'b0;
      op_done     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      rd_q        <= rd_d;
      prod_q      <= prod_d;
      mul_x       <= x_d;
      mul_y       <= y_d;
      wb_addr     <= wb_addr_d;
      wb_data     <= wb_data_d;
      mul_start   <= mul_start_d;
      wb_en       <= wb_en_d;
      op_done     <= op_done_d;
      timeout_err <= timeout_err_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_mul_writeback_ctrl.sv
// Directed bench for mul_writeback_ctrl with hand-computed expected writes.
module tb_mul_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [15:0] req_x, req_y;
  logic [2:0]  req_rd;
  logic        mul_start;
  logic [15:0] mul_x, mul_y;
  logic [31:0] mul_product;
  logic        mul_done;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        busy, op_done, timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mul_writeback_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rd(req_rd),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_product(mul_product), .mul_done(mul_done),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .op_done(op_done), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply: accept, drive done n cycles after mul_start is sampled,
  // check both writes, op_done timing and the accept-to-op_done latency.
  task automatic do_mul(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [2:0] rd, input int n, input logic [31:0] prod,
                        input logic [2:0] a0, input logic [15:0] d0,
                        input logic [2:0] a1, input logic [15:0] d1, input int exp_lat);
    int lat = 0;
    req_x = x; req_y = y; req_rd = rd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, " start"}, {31'd0, mul_start}, 32'd1);
    chk({tag, " mul_x"}, {16'd0, mul_x}, {16'd0, x});
    chk({tag, " mul_y"}, {16'd0, mul_y}, {16'd0, y});
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd0);
    for (int c = 1; c <= n + 3; c++) begin
      tick();
      mul_done    = (c == n);
      mul_product = (c == n) ? prod : 32'h0;
      if (op_done && lat == 0) lat = c + 1;
      if (c == 1) chk({tag, " start_pulse"}, {31'd0, mul_start}, 32'd0);
      if (c == n + 1) begin
        chk({tag, " wb_lo_en"}, {31'd0, wb_en}, 32'd1);
        chk({tag, " wb_lo_addr"}, {29'd0, wb_addr}, {29'd0, a0});
        chk({tag, " wb_lo_data"}, {16'd0, wb_data}, {16'd0, d0});
        chk({tag, " lo_op_done"}, {31'd0, op_done}, 32'd0);
      end else if (c == n + 2) begin
        chk({tag, " wb_hi_en"}, {31'd0, wb_en}, 32'd1);
        chk({tag, " wb_hi_addr"}, {29'd0, wb_addr}, {29'd0, a1});
        chk({tag, " wb_hi_data"}, {16'd0, wb_data}, {16'd0, d1});
        chk({tag, " hi_op_done"}, {31'd0, op_done}, 32'd1);
      end else begin
        chk({tag, " idle_wb_en"}, {31'd0, wb_en}, 32'd0);
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_rd = '0;
    mul_product = '0; mul_done = 1'b0;
    #23;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, mul_start}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_mul_x", {16'd0, mul_x}, 32'd0);
    chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
    reset = 1'b0;
    tick();

    do_mul("pos",  16'd3,    16'd4,   3'd2, 5, 32'h0000000C, 3'd2, 16'h000C, 3'd3, 16'h0000, 8);
    do_mul("neg",  16'hFFFE, 16'd3,   3'd4, 3, 32'hFFFFFFFA, 3'd4, 16'hFFFA, 3'd5, 16'hFFFF, 6);
    do_mul("wrap", 16'd300,  16'd300, 3'd7, 1, 32'h00015F90, 3'd7, 16'h5F90, 3'd0, 16'h0001, 4);

    // Watchdog: no done ever; abort 64 cycles after the START cycle.
    req_x = 16'd5; req_y = 16'd6; req_rd = 3'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      tick();
      if (wb_en) chk("to_wb_en", {31'd0, wb_en}, 32'd0);
      if (c == 64) chk("to_early", {31'd0, timeout_err}, 32'd0);
      if (c == 65) begin
        chk("to_pulse", {31'd0, timeout_err}, 32'd1);
        chk("to_ready", {31'd0, req_ready}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
      end
      if (c == 66) chk("to_one_cycle", {31'd0, timeout_err}, 32'd0);
    end

    // Back-to-back: req_valid held; second accept only after the first WB_HI.
    req_x = 16'd7; req_y = 16'd2; req_rd = 3'd3; req_valid = 1'b1;
    tick();
    req_x = 16'd3; req_y = 16'd3; req_rd = 3'd5;
    for (int c = 1; c <= 13; c++) begin
      tick();
      mul_done    = (c == 2) || (c == 8) || (c == 11);
      mul_product = (c == 2) ? 32'h0000000E : (c == 8) ? 32'h00000009 :
                    (c == 11) ? 32'hDEADBEEF : 32'h0;
      if (c <= 4) chk("b2b_stall", {31'd0, req_ready}, 32'd0);
      if (c == 3) chk("b2b_lo", {13'd0, wb_en, wb_addr, wb_data}, {13'd0, 1'b1, 3'd3, 16'h000E});
      if (c == 4) chk("b2b_hi", {13'd0, wb_en, wb_addr, wb_data}, {13'd0, 1'b1, 3'd4, 16'h0000});
      if (c == 5) begin
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        chk("b2b_no_start", {31'd0, mul_start}, 32'd0);
      end
      if (c == 6) begin
        chk("b2b_start2", {31'd0, mul_start}, 32'd1);
        chk("b2b_x2", {16'd0, mul_x}, 32'd3);
        req_valid = 1'b0;
      end
      if (c == 9)  chk("b2b_lo2", {13'd0, wb_en, wb_addr, wb_data}, {13'd0, 1'b1, 3'd5, 16'h0009});
      if (c == 10) chk("b2b_hi2", {13'd0, wb_en, wb_addr, wb_data}, {13'd0, 1'b1, 3'd6, 16'h0000});
      if (c >= 12) chk("spur_wb_en", {31'd0, wb_en}, 32'd0);
      if (c >= 12) chk("spur_busy", {31'd0, busy}, 32'd0);
    end

    // Reset during WAIT, then a late done: nothing may be written.
    req_x = 16'd9; req_y = 16'd9; req_rd = 3'd6; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_mul_x", {16'd0, mul_x}, 32'd0);
    #3 reset = 1'b0;
    tick();
    mul_done = 1'b1; mul_product = 32'h00000051;
    tick();
    mul_done = 1'b0; mul_product = 32'h0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rstw_no_wb", {13'd0, wb_en, wb_addr, wb_data}, 32'd0);
      chk("rstw_flags", {28'd0, busy, op_done, timeout_err, mul_start}, 32'd0);
    end
    chk("rstw_ready_end", {31'd0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
